// File: rtl/gcd_lcm_unit.sv
// Multi-cycle gcd/lcm unit: subtractive gcd, restoring division a0/g, then one multiply by b0.
// Start is honoured only in IDLE; Stall holds the pipeline until the DONE writeback cycle.
module gcd_lcm_unit #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              Start,
   input  logic              Op,
   input  logic [DATA_W-1:0] SrcA,
   input  logic [DATA_W-1:0] SrcB,
   output logic              Busy,
   output logic              Stall,
   output logic              Done,
   output logic [DATA_W-1:0] Result
);

   localparam int CNT_W = $clog2(DATA_W);

   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] GCD  = 3'd1;
   localparam logic [2:0] DIV  = 3'd2;
   localparam logic [2:0] MUL  = 3'd3;
   localparam logic [2:0] DONE = 3'd4;

   logic [2:0]        state;
   logic              op;
   logic [DATA_W-1:0] a0, b0, a, b, g, q, rem;
   logic [CNT_W-1:0]  cnt;
   logic [DATA_W-1:0] rem_nxt;
   logic              q_bit;

   // One restoring-division step: shift in the next dividend bit, subtract if it fits.
   function automatic logic [DATA_W:0] div_step(input logic [DATA_W-1:0] r,
                                                input logic              din,
                                                input logic [DATA_W-1:0] d);
      logic [DATA_W:0] sh;
      sh = {r, din};
      if (sh >= {1'b0, d})
         div_step = {1'b1, DATA_W'(sh - {1'b0, d})};
      else
         div_step = {1'b0, sh[DATA_W-1:0]};
   endfunction

   assign {q_bit, rem_nxt} = div_step(rem, a0[cnt], g);

   assign Busy  = (state != IDLE);
   assign Stall = (Start && state == IDLE) || state == GCD || state == DIV || state == MUL;
   assign Done  = (state == DONE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         op     <= 1'b0;
         a0     <= '0;
         b0     <= '0;
         a      <= '0;
         b      <= '0;
         g      <= '0;
         q      <= '0;
         rem    <= '0;
         cnt    <= '0;
         Result <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (Start) begin
                  a0 <= SrcA;
                  b0 <= SrcB;
                  op <= Op;
                  a  <= SrcA;
                  b  <= SrcB;
                  if (SrcA == '0 || SrcB == '0) begin
                     Result <= Op ? '0 : (SrcA | SrcB);
                     state  <= DONE;
                  end else begin
                     state  <= GCD;
                  end
               end
            end
            GCD: begin
               if (a == b) begin
                  g <= a;
                  if (!op) begin
                     Result <= a;
                     state  <= DONE;
                  end else begin
                     cnt   <= CNT_W'(DATA_W - 1);
                     rem   <= '0;
                     q     <= '0;
                     state <= DIV;
                  end
               end else if (a > b) begin
                  a <= a - b;
               end else begin
                  b <= b - a;
               end
            end
            DIV: begin
               rem    <= rem_nxt;
               q[cnt] <= q_bit;
               if (cnt == '0)
                  state <= MUL;
               else
                  cnt <= cnt - 1'b1;
            end
            MUL: begin
               // Product wider than DATA_W is dropped on purpose: the writeback is DATA_W bits.
               Result <= q * b0;
               state  <= DONE;
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gcd_lcm_unit.sv
// Scoreboard bench for gcd_lcm_unit: stimulus pushes expected result/latency, a monitor checks each Done.
module tb_gcd_lcm_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        Start = 1'b0;
   logic        Op = 1'b0;
   logic [31:0] SrcA = '0;
   logic [31:0] SrcB = '0;
   logic        Busy, Stall, Done;
   logic [31:0] Result;

   gcd_lcm_unit #(.DATA_W(32)) dut (
      .clk(clk), .reset(reset), .Start(Start), .Op(Op), .SrcA(SrcA), .SrcB(SrcB),
      .Busy(Busy), .Stall(Stall), .Done(Done), .Result(Result)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] res;
      int          lat;
      int          acc;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every Done pulse must match the oldest outstanding request.
   always @(negedge clk) begin
      if (!reset && Done) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done: Done=1 with no request outstanding (t=%0t)", $time);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("result", Result, e.res);
            chk("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
            chk("stall_at_done", {31'b0, Stall}, 32'd0);
         end
      end
   end

   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while (Busy && n < 90000) begin
         @(negedge clk);
         n++;
      end
      if (Busy) begin
         checks++;
         failures++;
         $display("FAIL idle_timeout: Busy=%0b after %0d cycles expected 0", Busy, n);
      end
   endtask

   task automatic issue(input logic op_i, input logic [31:0] a_i, input logic [31:0] b_i,
                        input logic [31:0] res, input int lat);
      exp_t e;
      wait_idle();
      Start = 1'b1;
      Op    = op_i;
      SrcA  = a_i;
      SrcB  = b_i;
      @(posedge clk);
      #1;
      e.res = res;
      e.lat = lat;
      e.acc = cyc;
      sb.push_back(e);
      Start = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 90000) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL drain_timeout: %0d results outstanding expected 0", sb.size());
         sb.delete();
      end
      @(negedge clk);
   endtask

   initial begin
      // reset state
      repeat (2) @(negedge clk);
      chk("reset_busy", {31'b0, Busy}, 32'd0);
      chk("reset_stall", {31'b0, Stall}, 32'd0);
      chk("reset_done", {31'b0, Done}, 32'd0);
      chk("reset_result", Result, 32'd0);
      reset = 1'b0;

      // gcd(12,8) with a re-pulsed Start and operand change during GCD, and a Start during DONE
      issue(1'b0, 32'd12, 32'd8, 32'd4, 4);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stall_gcd", {31'b0, Stall}, 32'd1);
         Start = (i == 0);
         SrcA  = 32'd99;
         SrcB  = 32'd33;
      end
      @(negedge clk);
      chk("done_cycle", {31'b0, Done}, 32'd1);
      Start = 1'b1;
      @(negedge clk);
      Start = 1'b0;
      repeat (3) @(negedge clk);
      chk("start_in_done_ignored", {31'b0, Busy}, 32'd0);
      drain();

      // lcm and zero-operand cases
      issue(1'b1, 32'd4, 32'd6, 32'd12, 37);
      issue(1'b0, 32'd0, 32'd7, 32'd7, 1);
      issue(1'b1, 32'd0, 32'd5, 32'd0, 1);
      issue(1'b0, 32'd0, 32'd0, 32'd0, 1);
      issue(1'b0, 32'd7, 32'd7, 32'd7, 2);
      issue(1'b1, 32'd3, 32'd5, 32'd15, 38);
      drain();
      repeat (3) @(negedge clk);
      chk("result_hold", Result, 32'd15);
      chk("idle_busy", {31'b0, Busy}, 32'd0);

      // reset in the middle of DIV for lcm(4,6)
      wait_idle();
      Start = 1'b1;
      Op    = 1'b1;
      SrcA  = 32'd4;
      SrcB  = 32'd6;
      @(negedge clk);
      Start = 1'b0;
      repeat (10) @(negedge clk);
      chk("mid_div_busy", {31'b0, Busy}, 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("abort_busy", {31'b0, Busy}, 32'd0);
      chk("abort_stall", {31'b0, Stall}, 32'd0);
      chk("abort_done", {31'b0, Done}, 32'd0);
      chk("abort_result", Result, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      repeat (40) @(negedge clk);
      chk("no_done_after_abort", Result, 32'd0);
      issue(1'b0, 32'd9, 32'd6, 32'd3, 4);
      drain();

      // truncated lcm with a long gcd phase
      issue(1'b1, 32'h0001_0000, 32'h0001_0001, 32'h0001_0000, 32'h10000 + 35);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/gcd_lcm_unit.md
GCD_LCM_UNIT -- requirements
Module: gcd_lcm_unit

Interface
REQ-001 The block SHALL use a single clock and an asynchronous, active-high reset, with ports named clk and reset.
REQ-002 The ports SHALL be as follows, with clk and reset listed first:
- clk  in  1  rising-edge clock
- reset  in  1  async, active-high
- Start  in  1  request from the main decoder (gcd/lcm opcode)
- Op  in  1  0 = gcd, 1 = lcm (driven by the decoder's ALU3SrcA bit)
- SrcA  in  32  unsigned operand a (rs1)
- SrcB  in  32  unsigned operand b (rs2)
- Busy  out  1  high while an operation is in flight
- Stall  out  1  freeze request to the PC/pipeline
- Done  out  1  one-cycle completion pulse
- Result  out  32  gcd or lcm value for register writeback

Function
REQ-003 The FSM SHALL have the states IDLE, GCD, DIV, MUL and DONE, encoded in 3 bits.
REQ-004 In IDLE, when Start=1, the block SHALL capture SrcA, SrcB and Op into internal registers a0, b0 and op, and SHALL load the working registers a and b.
  - If either operand is 0, it SHALL go to DONE with Result = (op ? 0 : a0|b0).
  - Otherwise it SHALL go to GCD.
REQ-005 In GCD, the block SHALL perform one step per cycle:
  - a==b: g<=a. If op=0, go to DONE with Result<=a. If op=1, go to DIV.
  - a>b: a<=a-b.
  - a<b: b<=b-a.
REQ-006 DIV SHALL perform a 32-iteration restoring division q=a0/g, one quotient bit per cycle, using a 5-bit counter that starts at 31 and exits to MUL after count 0.
REQ-007 MUL SHALL take one cycle, setting Result<=low 32 bits of q*b0, then go to DONE. An overflow beyond 32 bits SHALL be silently truncated.
REQ-008 DONE SHALL last exactly one cycle with Done=1, then return to IDLE.
REQ-009 Busy SHALL equal (state != IDLE).
REQ-010 Stall SHALL equal (Start & state==IDLE) | (state inside {GCD, DIV, MUL}). Stall SHALL be 0 in DONE, so that the writeback cycle coincides with Done.
REQ-011 Result SHALL hold its value from DONE until the next DONE. It SHALL NOT change in IDLE, GCD or DIV.
REQ-012 Start SHALL be ignored in every state other than IDLE; no queuing.
REQ-013 A Start in the same cycle as DONE SHALL be ignored. A new Start SHALL be accepted only in IDLE, one cycle after Done.
REQ-014 SrcA and SrcB SHALL be sampled only on the accepting edge; later changes SHALL have no effect.
REQ-015 Latency, measured from the accepting edge to Done high, SHALL be:
  - gcd: k+2 cycles, where k is the number of subtract steps.
  - lcm: k+35 cycles.
  - zero operand: 1 cycle.
REQ-016 The block SHALL be fully synchronous apart from reset. It SHALL contain no combinational path from Start to Done or Result; Start-to-Stall and Start-to-Busy-free Stall is the only such path.

Reset
REQ-017 While reset is asserted, state SHALL be IDLE and Busy, Stall (excluding its Start term), Done, Result, a, b, a0, b0, q, g and the counter SHALL all be 0.
REQ-018 A reset asserted mid-operation SHALL abort immediately and asynchronously. No Done pulse SHALL be produced for the aborted operation.
REQ-019 After reset deasserts, the first rising edge with Start=1 SHALL be accepted normally.

Verification
REQ-020 gcd(12,8): Op=0, SrcA=12, SrcB=8, Start pulse.
  - Steps: (12,8) -> (4,8) -> (4,4).
  - Required: Done 4 cycles after acceptance, Result=4, Stall high for 3 cycles after acceptance.
REQ-021 lcm(4,6): Op=1.
  - Required: g=2, q=2, Result=12, Done 37 cycles after acceptance (k=2).
REQ-022 Zero operands:
  - gcd(0,7): Result=7, Done on the cycle after acceptance.
  - lcm(0,5): Result=0, Done on the cycle after acceptance.
  - gcd(0,0): Result=0.
REQ-023 Start is re-pulsed with SrcA=99 during GCD of gcd(12,8).
  - Required: ignored; Result=4; exactly one Done.
  - A Start in the DONE cycle is also ignored.
REQ-024 reset is asserted mid-DIV during lcm(4,6).
  - Required: all outputs 0 immediately; no Done.
  - Then gcd(9,6) gives Result=3.
REQ-025 lcm(0x10000,0x10001):
  - Required: Result=0x00010000, the truncated low 32 bits of 0x100010000.
  - Done after k+35 cycles, with k=0x10000 subtract steps.
